// File: rtl/ram_src_pkg.sv
// rtl/ram_src_pkg.sv - shared state type, defaults and pattern helper for ram_source_bist (RAM_SRC_INV_PASS_EN adds WRITE2/READ2)
package ram_src_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;

`ifdef RAM_SRC_INV_PASS_EN
    typedef enum logic [2:0] {
        IDLE, WRITE, READ, CHECK, DONE, WRITE2, READ2
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, WRITE, READ, CHECK, DONE
    } state_t;
`endif

    // Callers truncate the result to their own word width.
    function automatic logic [31:0] pattern(input logic [31:0] a, input logic [31:0] seed);
        return a ^ seed;
    endfunction

endpackage

// File: rtl/ram_sp_sync.sv
// rtl/ram_sp_sync.sv - single-port synchronous read-first RAM; array is not reset, only the read register is
module ram_sp_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= data;
        end
    end

    // Non-blocking read alongside the write gives old-data (read-first) behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= r_mem[addr];
        end
    end

    assign q = r_q;

endmodule

// File: rtl/ram_source_bist.sv
// rtl/ram_source_bist.sv - write/read/compare BIST engine around a single-port RAM; RAM_SRC_INV_PASS_EN adds an inverted-pattern second pass
module ram_source_bist
    import ram_src_pkg::*;
#(
    parameter int                DATA_W = DATA_W_DEF,
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              inj_err,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] q
);

    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_valid;
    logic [ADDR_W:0]     r_err_cnt;
    logic                w_we;
    logic                w_busy;
    logic                w_done;
    logic                w_step;
    logic                w_last;
    logic                w_start_ok;
    logic                w_reading;
    logic [DATA_W-1:0]   w_wr_pat;
    logic [DATA_W-1:0]   w_exp;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W-1:0]   w_q;
    logic                w_mismatch;
`ifdef RAM_SRC_INV_PASS_EN
    logic                r_inv;
    logic                r_rd_inv;
`endif

    assign w_last     = (r_addr == ADDR_W'(DEPTH - 1));
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = WRITE;
            WRITE:      if (w_last) w_next = READ;
            READ:       if (w_last) w_next = CHECK;
`ifdef RAM_SRC_INV_PASS_EN
            CHECK:      w_next = r_inv ? DONE : WRITE2;
            WRITE2:     if (w_last) w_next = READ2;
            READ2:      if (w_last) w_next = CHECK;
`else
            CHECK:      w_next = DONE;
`endif
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        w_we      = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_reading = 1'b0;
        case (r_state)
            WRITE: begin w_we = 1'b1; w_busy = 1'b1; end
            READ:  begin w_reading = 1'b1; w_busy = 1'b1; end
            CHECK: w_busy = 1'b1;
            DONE:  w_done = 1'b1;
`ifdef RAM_SRC_INV_PASS_EN
            WRITE2: begin w_we = 1'b1; w_busy = 1'b1; end
            READ2:  begin w_reading = 1'b1; w_busy = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign w_step = w_we || w_reading;

`ifdef RAM_SRC_INV_PASS_EN
    assign w_wr_pat = (r_state == WRITE2) ? ~DATA_W'(pattern(32'(r_addr), 32'(SEED)))
                                          :  DATA_W'(pattern(32'(r_addr), 32'(SEED)));
    assign w_exp    = r_rd_inv ? ~DATA_W'(pattern(32'(r_rd_addr), 32'(SEED)))
                               :  DATA_W'(pattern(32'(r_rd_addr), 32'(SEED)));
`else
    assign w_wr_pat = DATA_W'(pattern(32'(r_addr), 32'(SEED)));
    assign w_exp    = DATA_W'(pattern(32'(r_rd_addr), 32'(SEED)));
`endif

    assign w_data     = w_we ? (w_wr_pat ^ DATA_W'(inj_err)) : '0;
    assign w_mismatch = r_rd_valid && (w_q != w_exp);

    // Read address is delayed one cycle to line up with the RAM's registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_rd_addr  <= '0;
            r_rd_valid <= 1'b0;
            r_err_cnt  <= '0;
`ifdef RAM_SRC_INV_PASS_EN
            r_inv      <= 1'b0;
            r_rd_inv   <= 1'b0;
`endif
        end else begin
            r_rd_valid <= w_reading;
            r_rd_addr  <= r_addr;
`ifdef RAM_SRC_INV_PASS_EN
            r_rd_inv   <= (r_state == READ2);
            if (w_start_ok) begin
                r_inv <= 1'b0;
            end else if (r_state == CHECK) begin
                r_inv <= 1'b1;
            end
`endif
            if (w_start_ok) begin
                r_addr    <= '0;
                r_err_cnt <= '0;
            end else begin
                if (w_step) begin
                    r_addr <= r_addr + 1'b1;
                end
                if (w_mismatch && (r_err_cnt != CNT_MAX)) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    ram_sp_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we),
        .addr  (r_addr),
        .data  (w_data),
        .q     (w_q)
    );

    assign busy    = w_busy;
    assign done    = w_done;
    assign pass    = w_done && (r_err_cnt == '0);
    assign err_cnt = r_err_cnt;
    assign addr    = r_addr;
    assign we      = w_we;
    assign data    = w_data;
    assign q       = w_q;

endmodule

// File: tb/tb_ram_source_bist.sv
// tb/tb_ram_source_bist.sv - directed and randomized bench for ram_source_bist with a behavioural memory model
module tb_ram_source_bist;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       inj_err = 1'b0;
    logic       busy, done, pass, we;
    logic [6:0] err_cnt;
    logic [5:0] addr;
    logic [7:0] data, q;

    int passed = 0;
    int total  = 0;
    logic [7:0] model_mem [64];

    always #5 clk = ~clk;

    ram_source_bist dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .inj_err (inj_err),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt),
        .addr    (addr),
        .we      (we),
        .data    (data),
        .q       (q)
    );

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'hA5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_we"}, we, 0);
        check({tag, "_data"}, data, 0);
    endtask

    // One BIST run: mask selects inj_err per write address, mid_k pulses start
    // before edge mid_k, abort_k asserts reset before edge abort_k (0 = never).
    task automatic run(input string tag, input logic [63:0] mask, input int mid_k, input int abort_k);
        int done_k;
        int exp_err;
        @(negedge clk);
        start   = 1'b1;
        inj_err = 1'($urandom);
        @(posedge clk); #1;
        check({tag, "_start_busy"}, busy, 1);
        check({tag, "_start_done"}, done, 0);
        done_k = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start   = (k == mid_k);
            inj_err = (k <= 64) ? mask[k-1] : 1'($urandom);
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs({tag, "_abort"});
                check({tag, "_abort_q"}, q, 0);
                @(negedge clk);
                rst_n   = 1'b1;
                start   = 1'b0;
                inj_err = 1'b0;
                @(posedge clk); #1;
                check_reset_outputs({tag, "_post_abort"});
                return;
            end
            #1;
            if (k <= 64) begin
                check($sformatf("%s_we%0d", tag, k), we, 1);
                check($sformatf("%s_data%0d", tag, k), data, pat(k-1) ^ {7'b0, mask[k-1]});
            end else if (k >= 66 && k <= 129) begin
                check($sformatf("%s_q%0d", tag, k), q, model_mem[k-66]);
            end
            @(posedge clk); #1;
            if (k <= 64) model_mem[k-1] = pat(k-1) ^ {7'b0, mask[k-1]};
            if (done) begin
                done_k = k;
                break;
            end
        end
        start   = 1'b0;
        inj_err = 1'b0;
        exp_err = 0;
        for (int a = 0; a < 64; a++) begin
            if (model_mem[a] !== pat(a)) exp_err++;
        end
        if (exp_err > 64) exp_err = 64;
        check({tag, "_latency"}, done_k, 129);
        check({tag, "_err_cnt"}, err_cnt, exp_err);
        check({tag, "_pass"}, pass, (exp_err == 0));
        check({tag, "_busy_done"}, busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_hold"}, done, 1);
        check({tag, "_err_hold"}, err_cnt, exp_err);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_active");
        check("rst_active_q", q, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("rst_release");

        run("clean", 64'h0, 0, 0);
        run("inj5to7", 64'hE0, 0, 0);
        run("full1", '1, 0, 0);
        run("full2", '1, 0, 0);
        run("midstart", 64'h0, $urandom_range(66, 128), 0);
        for (int i = 0; i < 3; i++) begin
            run($sformatf("rand%0d", i), {$urandom, $urandom}, 0, 0);
        end
        run("abort", 64'h0, 0, 31);
        run("after_abort", 64'h0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_source_bist.md
Name: ram_source_bist

Overview:
- Self-checking memory test engine: a single-port synchronous RAM plus a stimulus/checker FSM that drives it.
- On a start pulse, the FSM writes a deterministic pattern to every word, reads every word back and compares it against the expected value.
- Reports done, pass and an error count.
- Sits beside datapath RAMs as a built-in self test; the internal RAM bus is exported for waveform debug.

Parameters:
- DATA_W, 8, RAM word width in bits.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W (64 words).
- SEED, 8'hA5, pattern key; pattern(a) = zero-extended a XOR SEED, truncated to DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; honoured only in IDLE or DONE.
- inj_err  in  1  when high during a write cycle, bit 0 of the written data is inverted (fault injection).
- busy  out  1  high in WRITE, READ and CHECK.
- done  out  1  high in DONE until the next start.
- pass  out  1  valid while done: 1 if err_cnt == 0.
- err_cnt  out  ADDR_W+1  number of mismatching words, saturating at DEPTH.
- addr  out  ADDR_W  RAM address bus (debug).
- we  out  1  RAM write enable (debug).
- data  out  DATA_W  RAM write data (debug).
- q  out  DATA_W  RAM read data (debug).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state IDLE, addr 0, we 0, data 0, q 0, busy 0, done 0, pass 0, err_cnt 0. RAM contents are not reset.
- RAM write: at each rising edge, if we is high, mem[addr] <= data.
- RAM read: q <= mem[addr] every rising edge, one-cycle latency. Read-first: on a simultaneous write, q gets the old content.
- IDLE:
  - start=1 clears err_cnt and goes to WRITE with addr=0.
- WRITE, DEPTH cycles:
  - we=1, data = pattern(addr) ^ {0..,inj_err}; addr increments each cycle.
  - After addr=DEPTH-1, go to READ with addr wrapped to 0 and we=0.
- READ, DEPTH cycles:
  - we=0; addr increments each cycle.
  - One cycle after each read address, q is compared with pattern of the registered previous address. A mismatch increments err_cnt (saturating).
  - After addr=DEPTH-1, go to CHECK.
- CHECK, 1 cycle:
  - Compares the last word, then goes to DONE.
- DONE:
  - done=1 and pass=(err_cnt==0), both held.
  - start=1 restarts exactly as from IDLE; done drops on the same edge.
- Latency: done rises 2*DEPTH+1 cycles after the start edge (129 at defaults).
- start while busy is ignored. inj_err outside WRITE has no effect.
- rst_n low mid-run aborts immediately to the reset values. Memory keeps whatever was written.
- data is 0 whenever we=0.

Optional Feature:
- Macro RAM_SRC_INV_PASS_EN.
- When defined: after the first READ phase, a second WRITE/READ pass runs with the inverted pattern (~pattern(a)). Errors from both passes accumulate in err_cnt; done latency becomes 4*DEPTH+2 cycles.
- When undefined: single pass only, as above.

Decomposition:
- Shared package ram_src_pkg holds:
  - state enum (IDLE, WRITE, READ, CHECK, DONE, plus WRITE2/READ2 under the macro);
  - DATA_W/ADDR_W defaults;
  - a pattern function.
- One natural sub-module: ram_sp_sync (DEPTH x DATA_W synchronous read-first RAM, ports clk, we, addr, data, q; no reset on the array).
- The FSM/checker stays in the top.

Test Plan:
- Reset: rst_n low, then high → all outputs 0, state IDLE, done=0.
- Clean run: start pulse with inj_err=0 → we high for 64 cycles with data 8'hA5,8'hA4,8'hA7,…; done at cycle 129, pass=1, err_cnt=0.
- Fault injection: inj_err high for the 3 write cycles at addr 5..7 → done with pass=0, err_cnt=3.
- Full fault: inj_err held high through WRITE → err_cnt=64, pass=0; further starts with inj_err held high keep err_cnt at 64 (saturating).
- Busy and restart: start pulsed mid-READ → ignored, done still at cycle 129; start pulsed in DONE → done drops, new run passes.
- Reset abort: rst_n asserted at write addr 30 → outputs return to reset values; a following clean start yields pass=1.
